vga_sync_decoder: RTL
=====================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_TOTAL, 1344, pixels per line.
- H_ACTIVE, 1024, visible pixels.
- H_SYNC_START, 1048, hcount at hsync leading edge.
- V_TOTAL, 806, lines per frame.
- V_ACTIVE, 768, visible lines.
- V_SYNC_START, 771, vcount at vsync leading edge.
- SYNC_POL, 1'b0, active level of hsync_in and vsync_in.
- LOCK_FRAMES, 2, clean frames required to lock.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- pclk, in, 1, pixel clock; the only clock.
- rst, in, 1, synchronous active-high reset.
- hsync_in, in, 1, received horizontal sync.
- vsync_in, in, 1, received vertical sync.
- rgb_in, in, 12, received pixel {r,g,b}.
- hcount_out, out, 11, recovered horizontal position.
- vcount_out, out, 11, recovered vertical position.
- de_out, out, 1, active-area pixel valid.
- rgb_out, out, 12, pixel, blanked to 0 outside active area.
- locked, out, 1, timing locked.
- frame_start, out, 1, one-cycle pulse at pixel (0,0).
- sync_err, out, 1, one-cycle pulse on sync mismatch while acquiring or locked.

Function
REQ-003 All inputs SHALL be registered once; all outputs SHALL be registered; pixel sampled at cycle t SHALL appear on outputs at cycle t+2.
REQ-004 Sync leading edge = registered sync changes from !SYNC_POL to SYNC_POL.
REQ-005 Predicted position:
- h_pred SHALL be the previous h plus 1, wrapping H_TOTAL-1 -> 0.
- v_pred SHALL increment on each h wrap, wrapping V_TOTAL-1 -> 0.
REQ-006 On an hsync leading edge, h for that sample SHALL be H_SYNC_START; otherwise h SHALL be h_pred.
REQ-007 On a vsync leading edge, v for that sample SHALL be V_SYNC_START; otherwise v SHALL be v_pred.
REQ-008 hsync mismatch SHALL be either:
- a leading edge with h_pred != H_SYNC_START; or
- h_pred == H_SYNC_START with no leading edge.
REQ-009 vsync mismatch SHALL be either:
- a leading edge with v_pred != V_SYNC_START; or
- an h wrap out of line V_SYNC_START with no vsync leading edge seen during that line.
REQ-010 FSM states SHALL be SEARCH, ACQUIRE and LOCKED.
- SEARCH -> ACQUIRE on the first vsync leading edge; good_cnt cleared.
- ACQUIRE: each vsync leading edge with no mismatch since the previous one SHALL increment good_cnt; at good_cnt == LOCK_FRAMES -> LOCKED.
- ACQUIRE or LOCKED: any mismatch SHALL pulse sync_err and go to SEARCH.
- SEARCH SHALL ignore mismatches and never pulse sync_err.
REQ-011 A mismatch in the same cycle as a qualifying vsync edge SHALL take priority: no increment, go to SEARCH.
REQ-012 locked SHALL be 1 exactly when the state is LOCKED, registered, aligned with the output pixel.
REQ-013 de_out SHALL be locked & h<H_ACTIVE & v<V_ACTIVE; rgb_out SHALL be rgb_in when de_out=1, else 12'h000.
REQ-014 frame_start SHALL pulse when locked and h==0 and v==0.
REQ-015 hcount_out and vcount_out SHALL output h and v in every state, including SEARCH.
REQ-016 Counter arithmetic SHALL be 11-bit unsigned; good_cnt SHALL be sized to hold LOCK_FRAMES.

Reset
REQ-017 While rst=1 at a pclk edge, the block SHALL enter SEARCH and hold:
- h, v, good_cnt and sync history cleared (sync history set to !SYNC_POL);
- all outputs 0.
REQ-018 rst asserted mid-frame SHALL abandon lock immediately; reacquisition SHALL restart from SEARCH.

Structure
REQ-019 The XGA timing constants (H_*, V_*) SHALL be placed in a shared package/include alongside the timing generator's constants, so generator and decoder cannot diverge.
REQ-020 One sub-module, sync_edge_detect (register plus leading-edge pulse, polarity parameter), SHALL be instantiated once for hsync and once for vsync.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then drive the vga_timing stream: SEARCH at the first vsync edge; locked=1 two cycles after the third vsync edge; no sync_err.
- Locked stream, pixel (0,0) with rgb_in=12'hABC: frame_start=1, de_out=1, rgb_out=12'hABC two cycles later; at hcount 1024, de_out=0 and rgb_out=0.
- Locked, one hsync pulse suppressed: sync_err pulses once at predicted h=1048; locked=0; relock after LOCK_FRAMES+1 clean vsync edges.
- Locked, one hsync pulse arrives 4 pixels early: sync_err; hcount_out realigns to 1048 at the early edge.
- ACQUIRE, vsync edge on line 772: sync_err and SEARCH; good_cnt does not increment.
- rst pulsed mid-frame while locked: all outputs 0 next cycle; lock regained only after three further vsync edges.

Source files
------------

// File: rtl/vga_sync_decoder_pkg.sv
// Shared XGA (1024x768 @ 60 Hz) timing constants for the timing generator and the
// sync decoder, plus the decoder's state type and counter helpers.
package vga_sync_decoder_pkg;

    localparam int CNT_W = 11;

    // Horizontal timing in pixels: active, front porch 24, sync 136, back porch 160
    localparam int XGA_H_TOTAL      = 1344;
    localparam int XGA_H_ACTIVE     = 1024;
    localparam int XGA_H_SYNC_START = 1048;
    localparam int XGA_H_SYNC_END   = 1184;

    // Vertical timing in lines: active, front porch 3, sync 6, back porch 29
    localparam int XGA_V_TOTAL      = 806;
    localparam int XGA_V_ACTIVE     = 768;
    localparam int XGA_V_SYNC_START = 771;
    localparam int XGA_V_SYNC_END   = 777;

    typedef logic [CNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ACQUIRE,
        ST_LOCKED
    } sync_state_t;

    function automatic count_t wrap_inc(input count_t val, input count_t last);
        return (val == last) ? '0 : val + count_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// Registers one received sync line and flags the sample where it first becomes
// active (inactive -> POL) relative to the previous registered sample.
module sync_edge_detect #(
    parameter logic POL = 1'b0
) (
    input  logic pclk,
    input  logic rst,
    input  logic sync_in,
    output logic lead_edge
);

    logic sync_reg;
    logic sync_prev;

    always_ff @(posedge pclk) begin
        if (rst) begin
            sync_reg  <= ~POL;
            sync_prev <= ~POL;
        end else begin
            sync_reg  <= sync_in;
            sync_prev <= sync_reg;
        end
    end

    assign lead_edge = (sync_reg == POL) && (sync_prev != POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from received H/V sync, locks after a run of clean frames,
// and re-emits the pixel stream with data-enable and blanking two cycles later.
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int   H_TOTAL      = XGA_H_TOTAL,
    parameter int   H_ACTIVE     = XGA_H_ACTIVE,
    parameter int   H_SYNC_START = XGA_H_SYNC_START,
    parameter int   V_TOTAL      = XGA_V_TOTAL,
    parameter int   V_ACTIVE     = XGA_V_ACTIVE,
    parameter int   V_SYNC_START = XGA_V_SYNC_START,
    parameter logic SYNC_POL     = 1'b0,
    parameter int   LOCK_FRAMES  = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        de_out,
    output logic [11:0] rgb_out,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err
);

    localparam int     GOOD_W  = $clog2(LOCK_FRAMES + 1);
    localparam count_t H_LAST  = count_t'(H_TOTAL - 1);
    localparam count_t V_LAST  = count_t'(V_TOTAL - 1);
    localparam count_t H_SS    = count_t'(H_SYNC_START);
    localparam count_t V_SS    = count_t'(V_SYNC_START);
    localparam count_t H_ACT   = count_t'(H_ACTIVE);
    localparam count_t V_ACT   = count_t'(V_ACTIVE);

    logic [11:0]       rgb_reg;
    logic              h_edge;
    logic              v_edge;

    count_t            h;
    count_t            v;
    count_t            h_pred;
    count_t            v_pred;
    count_t            h_next;
    count_t            v_next;
    logic              h_wrap;
    logic              v_seen;
    logic              v_seen_next;
    logic              h_mis;
    logic              v_mis;
    logic              mismatch;

    sync_state_t       state;
    sync_state_t       state_next;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_next;
    logic [GOOD_W-1:0] good_inc;
    logic              err_next;
    logic              locked_next;
    logic              de_next;

    sync_edge_detect #(.POL(SYNC_POL)) u_hsync_edge (
        .pclk      (pclk),
        .rst       (rst),
        .sync_in   (hsync_in),
        .lead_edge (h_edge)
    );

    sync_edge_detect #(.POL(SYNC_POL)) u_vsync_edge (
        .pclk      (pclk),
        .rst       (rst),
        .sync_in   (vsync_in),
        .lead_edge (v_edge)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_reg <= '0;
        end else begin
            rgb_reg <= rgb_in;
        end
    end

    // Free-running prediction, overridden by sync edges; a sync that disagrees with
    // the prediction (early, late or missing) counts as a mismatch.
    always_comb begin
        h_wrap      = (h == H_LAST);
        h_pred      = wrap_inc(h, H_LAST);
        v_pred      = h_wrap ? wrap_inc(v, V_LAST) : v;
        h_next      = h_edge ? H_SS : h_pred;
        v_next      = v_edge ? V_SS : v_pred;
        h_mis       = (h_edge && (h_pred != H_SS)) || (!h_edge && (h_pred == H_SS));
        v_mis       = (v_edge && (v_pred != V_SS)) || (h_wrap && (v == V_SS) && !v_seen);
        mismatch    = h_mis || v_mis;
        v_seen_next = h_wrap ? v_edge : (v_seen || v_edge);
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        good_inc   = good_cnt + GOOD_W'(1);
        err_next   = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (v_edge) begin
                    state_next = ST_ACQUIRE;
                    good_next  = '0;
                end
            end
            ST_ACQUIRE: begin
                // A mismatch on the same sample as a vsync edge wins over the count
                if (mismatch) begin
                    state_next = ST_SEARCH;
                    err_next   = 1'b1;
                end else if (v_edge) begin
                    good_next = good_inc;
                    if (good_inc == GOOD_W'(LOCK_FRAMES)) begin
                        state_next = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (mismatch) begin
                    state_next = ST_SEARCH;
                    err_next   = 1'b1;
                end
            end
            default: begin
                state_next = ST_SEARCH;
                good_next  = '0;
            end
        endcase
        locked_next = (state_next == ST_LOCKED);
        de_next     = locked_next && (h_next < H_ACT) && (v_next < V_ACT);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= ST_SEARCH;
            good_cnt    <= '0;
            h           <= '0;
            v           <= '0;
            v_seen      <= 1'b0;
            locked      <= 1'b0;
            de_out      <= 1'b0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_next;
            good_cnt    <= good_next;
            h           <= h_next;
            v           <= v_next;
            v_seen      <= v_seen_next;
            locked      <= locked_next;
            de_out      <= de_next;
            rgb_out     <= de_next ? rgb_reg : 12'h000;
            frame_start <= locked_next && (h_next == '0) && (v_next == '0);
            sync_err    <= err_next;
        end
    end

    assign hcount_out = h;
    assign vcount_out = v;

endmodule
